// File: rtl/variance_cache_reader_pkg.sv
// Shared widths, FSM state type and the corner map for the variance cache reader.
package pkg_varianceCache;

    localparam int ADDR_WIDTH   = 2;
    localparam int WORD_SIZE    = 32;
    localparam int WORD_SIZE_SQ = 64;
    localparam int AREA_W       = 16;
    localparam int VAR_W        = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_MUL   = 3'd3,
        ST_SUB   = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    // Window corners as stored in the cache.
    localparam logic [ADDR_WIDTH-1:0] CORNER_TL = 2'd0;
    localparam logic [ADDR_WIDTH-1:0] CORNER_TR = 2'd1;
    localparam logic [ADDR_WIDTH-1:0] CORNER_BL = 2'd2;
    localparam logic [ADDR_WIDTH-1:0] CORNER_BR = 2'd3;

    // Bit i set: corner i is subtracted (window sum = TL - TR - BL + BR).
    localparam logic [3:0] CORNER_SUB = 4'b0110;

    function automatic logic corner_is_sub(input logic [ADDR_WIDTH-1:0] idx);
        return CORNER_SUB[idx];
    endfunction

endpackage

// File: rtl/variance_cache_reader_mul_sub.sv
// MUL and SUB pipeline stages: area*sqsum and sum^2, then clamped difference.
module variance_mul_sub
    import pkg_varianceCache::*;
#(
    parameter int P_AREA_W       = AREA_W,
    parameter int P_WORD_SIZE    = WORD_SIZE,
    parameter int P_WORD_SIZE_SQ = WORD_SIZE_SQ,
    parameter int P_VAR_W        = VAR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mul_en,
    input  logic                      sub_en,
    input  logic [P_AREA_W-1:0]       area,
    input  logic [P_WORD_SIZE-1:0]    sum,
    input  logic [P_WORD_SIZE_SQ-1:0] sqsum,
    output logic [P_VAR_W-1:0]        variance
);

    localparam int PROD_W   = P_AREA_W + P_WORD_SIZE_SQ;
    localparam int SUMSQ_W  = 2 * P_WORD_SIZE;
    localparam int DIFF_W   = ((PROD_W > SUMSQ_W) ? PROD_W : SUMSQ_W) + 1;

    logic [PROD_W-1:0]  prod_area;
    logic [SUMSQ_W-1:0] prod_sum;
    logic [DIFF_W-1:0]  diff;
    logic [P_VAR_W-1:0] var_clamped;

    // Product registers, loaded once per computation in the MUL state.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_area <= '0;
            prod_sum  <= '0;
        end else if (mul_en) begin
            prod_area <= PROD_W'(area) * PROD_W'(sqsum);
            prod_sum  <= SUMSQ_W'(sum) * SUMSQ_W'(sum);
        end
    end

    // One extra bit so the sign of the difference is never lost; clamp below, saturate above.
    always_comb begin
        var_clamped = '0;
        diff        = DIFF_W'(prod_area) - DIFF_W'(prod_sum);
        if (diff[DIFF_W-1]) begin
            var_clamped = '0;
        end else if (diff[DIFF_W-2:P_VAR_W] != '0) begin
            var_clamped = '1;
        end else begin
            var_clamped = diff[P_VAR_W-1:0];
        end
    end

    // Result register, held stable until the next SUB state.
    always_ff @(posedge clk) begin
        if (reset) begin
            variance <= '0;
        end else if (sub_en) begin
            variance <= var_clamped;
        end
    end

endmodule

// File: rtl/variance_cache_reader.sv
// Reads the four window corners from the variance cache and produces the
// unnormalised window variance AREA*sqsum - sum^2 over a valid/ready port.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | ready_o=1, waiting for start_i
// READ     | four read strobes, addresses 0..3, returns accumulated
// DRAIN    | no strobe, last (BR) return accumulated
// MUL      | area*sqsum and sum*sum registered
// SUB      | clamped difference registered into variance_o
// OUT      | valid_o=1 until ready_i
module variance_cache_reader
    import pkg_varianceCache::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic [AREA_W-1:0]       win_area_i,
    output logic                    ready_o,
    output logic                    rd_en_o,
    output logic [ADDR_WIDTH-1:0]   rd_addr_o,
    input  logic [WORD_SIZE-1:0]    rd_data_i,
    input  logic [WORD_SIZE_SQ-1:0] rd_data_sq_i,
    output logic [VAR_W-1:0]        variance_o,
    output logic                    valid_o,
    input  logic                    ready_i
);

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH-1:0]   rd_left;
    logic                    rd_vld_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic [AREA_W-1:0]       area_q;
    logic [WORD_SIZE-1:0]    sum_q;
    logic [WORD_SIZE_SQ-1:0] sqsum_q;
    logic                    start_acc;
    logic                    mul_en;
    logic                    sub_en;

    assign start_acc = (state == ST_IDLE) && start_i;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_i) state_nxt = ST_READ;
            ST_READ:  if (rd_left == '0) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_MUL;
            ST_MUL:   state_nxt = ST_SUB;
            ST_SUB:   state_nxt = ST_OUT;
            ST_OUT:   if (ready_i) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; the address is derived from the remaining-read count.
    always_comb begin
        ready_o   = (state == ST_IDLE);
        rd_en_o   = (state == ST_READ);
        valid_o   = (state == ST_OUT);
        mul_en    = (state == ST_MUL);
        sub_en    = (state == ST_SUB);
        rd_addr_o = CORNER_BR - rd_left;
    end

    // Remaining-read down-counter; rests at 3 so the idle address is 0 and wraps back after the last read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_left <= CORNER_BR;
        end else if (state == ST_READ) begin
            rd_left <= rd_left - 1'b1;
        end
    end

    // Track which corner's data arrives this cycle (one-cycle cache latency).
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rd_vld_q  <= rd_en_o;
            rd_addr_q <= rd_addr_o;
        end
    end

    // Area latch and signed-by-corner accumulation, both wrapping at their word widths.
    always_ff @(posedge clk) begin
        if (reset) begin
            area_q  <= '0;
            sum_q   <= '0;
            sqsum_q <= '0;
        end else if (start_acc) begin
            area_q  <= win_area_i;
            sum_q   <= '0;
            sqsum_q <= '0;
        end else if (rd_vld_q) begin
            if (corner_is_sub(rd_addr_q)) begin
                sum_q   <= sum_q - rd_data_i;
                sqsum_q <= sqsum_q - rd_data_sq_i;
            end else begin
                sum_q   <= sum_q + rd_data_i;
                sqsum_q <= sqsum_q + rd_data_sq_i;
            end
        end
    end

    variance_mul_sub u_mul_sub (
        .clk      (clk),
        .reset    (reset),
        .mul_en   (mul_en),
        .sub_en   (sub_en),
        .area     (area_q),
        .sum      (sum_q),
        .sqsum    (sqsum_q),
        .variance (variance_o)
    );

endmodule

// File: tb/tb_variance_cache_reader.sv
// Directed bench for variance_cache_reader with a one-cycle-latency cache model and a result scoreboard.
module tb_variance_cache_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [15:0] win_area_i;
    logic        ready_o;
    logic        rd_en_o;
    logic [1:0]  rd_addr_o;
    logic [31:0] rd_data_i;
    logic [63:0] rd_data_sq_i;
    logic [63:0] variance_o;
    logic        valid_o;
    logic        ready_i;

    logic [31:0] mem    [4];
    logic [63:0] mem_sq [4];
    logic [1:0]  model_addr;
    int          read_count = 0;

    logic [63:0] sb[$];
    int checks   = 0;
    int failures = 0;

    variance_cache_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .win_area_i   (win_area_i),
        .ready_o      (ready_o),
        .rd_en_o      (rd_en_o),
        .rd_addr_o    (rd_addr_o),
        .rd_data_i    (rd_data_i),
        .rd_data_sq_i (rd_data_sq_i),
        .variance_o   (variance_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i)
    );

    always #5 clk = ~clk;

    // Cache model: strobe seen mid-cycle, data presented just after the following edge.
    always @(negedge clk) begin
        if (rd_en_o === 1'b1) begin
            model_addr = rd_addr_o;
            read_count++;
            @(posedge clk);
            #1;
            rd_data_i    = mem[model_addr];
            rd_data_sq_i = mem_sq[model_addr];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, b, c, d, input logic [63:0] qa, qb, qc, qd);
        mem[0] = a;  mem[1] = b;  mem[2] = c;  mem[3] = d;
        mem_sq[0] = qa; mem_sq[1] = qb; mem_sq[2] = qc; mem_sq[3] = qd;
    endtask

    function automatic logic [63:0] model(input logic [15:0] ar);
        logic [31:0] s;
        logic [63:0] q;
        logic [79:0] p1;
        logic [79:0] p2;
        s  = mem[0] - mem[1] - mem[2] + mem[3];
        q  = mem_sq[0] - mem_sq[1] - mem_sq[2] + mem_sq[3];
        p1 = 80'(ar) * 80'(q);
        p2 = 80'(s) * 80'(s);
        if (p1 < p2) return 64'd0;
        if ((p1 - p2) > 80'h0000_FFFF_FFFF_FFFF_FFFF) return '1;
        return 64'(p1 - p2);
    endfunction

    // Presents start for one edge (the start edge); returns just after it. Area is then scrambled.
    task automatic start_op(input logic [15:0] area, input logic [63:0] exp);
        @(negedge clk);
        start_i    = 1'b1;
        win_area_i = area;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        start_i    = 1'b0;
        win_area_i = 16'($urandom);
    endtask

    task automatic wait_and_check(input string tag);
        int n;
        logic [63:0] exp;
        n = 0;
        while (valid_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (valid_o !== 1'b1) begin
            check({tag, "_timeout"}, {63'd0, valid_o}, 64'd1);
        end else if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            exp = sb.pop_front();
            check(tag, variance_o, exp);
        end
    endtask

    initial begin
        int rc;
        int v1;
        int v2;
        int nv;
        logic [63:0] held;
        logic [15:0] ar;

        reset = 1'b1; start_i = 1'b0; win_area_i = '0; ready_i = 1'b1;
        rd_data_i = '0; rd_data_sq_i = '0;
        load(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", {63'd0, ready_o}, 64'd1);
        check("rst_rd_en", {63'd0, rd_en_o}, 64'd0);
        check("rst_addr", {62'd0, rd_addr_o}, 64'd0);
        check("rst_valid", {63'd0, valid_o}, 64'd0);
        check("rst_var", variance_o, 64'd0);

        // Basic with cycle-accurate timing.
        load(5, 7, 9, 21, 1, 2, 3, 34);
        start_op(16'd4, 64'd20);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("basic_rd_en_c%0d", c), {63'd0, rd_en_o}, (c <= 4) ? 64'd1 : 64'd0);
            if (c <= 4) check($sformatf("basic_addr_c%0d", c), {62'd0, rd_addr_o}, 64'(c - 1));
            check($sformatf("basic_valid_c%0d", c), {63'd0, valid_o}, (c == 8) ? 64'd1 : 64'd0);
        end
        wait_and_check("basic_var");
        @(negedge clk);
        check("basic_idle_ready", {63'd0, ready_o}, 64'd1);
        check("basic_idle_valid", {63'd0, valid_o}, 64'd0);

        // Wrapped integral values.
        load(0, 32'hFFFF_FFF8, 2, 4, 1, 2, 3, 34);
        start_op(16'd4, 64'd20);
        wait_and_check("wrap_var");
        @(negedge clk);

        // Reset while reading addr2; the following op must not see the aborted partial sums.
        load(100, 1, 1, 100, 900, 1, 1, 900);
        start_op(16'd9, 64'd0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("abort_addr2", {62'd0, rd_addr_o}, 64'd2);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_rd_en", {63'd0, rd_en_o}, 64'd0);
        check("abort_ready", {63'd0, ready_o}, 64'd1);
        check("abort_valid", {63'd0, valid_o}, 64'd0);
        check("abort_var", variance_o, 64'd0);
        sb.delete();
        load(5, 7, 9, 21, 1, 2, 3, 34);
        start_op(16'd4, 64'd20);
        wait_and_check("after_abort_var");
        @(negedge clk);

        // Flat window and a negative difference clamp to 0.
        load(0, 0, 0, 28, 0, 0, 0, 196);
        start_op(16'd4, 64'd0);
        wait_and_check("flat_var");
        @(negedge clk);
        load(0, 0, 0, 10, 0, 0, 0, 20);
        start_op(16'd4, 64'd0);
        wait_and_check("neg_clamp_var");
        @(negedge clk);

        // Saturation above 2^64-1.
        load(0, 0, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        start_op(16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_and_check("sat_var");
        @(negedge clk);

        // Backpressure with ignored starts.
        load(3, 1, 1, 9, 10, 1, 1, 50);
        ready_i = 1'b0;
        start_op(16'd8, model(16'd8));
        wait_and_check("bp_var");
        held = variance_o;
        rc   = read_count;
        for (int k = 1; k <= 5; k++) begin
            start_i = k[0];
            @(negedge clk);
            check($sformatf("bp_valid_%0d", k), {63'd0, valid_o}, 64'd1);
            check($sformatf("bp_hold_%0d", k), variance_o, held);
            check($sformatf("bp_rd_en_%0d", k), {63'd0, rd_en_o}, 64'd0);
        end
        start_i = 1'b0;
        check("bp_no_reads", 64'(read_count), 64'(rc));
        ready_i = 1'b1;
        @(negedge clk);
        check("bp_ready_after", {63'd0, ready_o}, 64'd1);
        check("bp_valid_after", {63'd0, valid_o}, 64'd0);

        // Randomised corners against the reference model.
        for (int r = 0; r < 4; r++) begin
            load($urandom, $urandom, $urandom, $urandom,
                 {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            if (r[0]) mem_sq[3] = 64'(mem_sq[1]) + 64'(mem_sq[2]) - 64'(mem_sq[0]) + 64'd1000;
            ar = 16'($urandom_range(1, 65535));
            start_op(ar, model(ar));
            wait_and_check($sformatf("rand_var_%0d", r));
            @(negedge clk);
        end

        // Back-to-back with start held high.
        load(5, 7, 9, 21, 1, 2, 3, 34);
        read_count = 0;
        v1 = 0; v2 = 0; nv = 0;
        @(negedge clk);
        start_i    = 1'b1;
        win_area_i = 16'd4;
        sb.push_back(64'd20);
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (valid_o === 1'b1) begin
                nv++;
                if (nv == 1) v1 = c; else v2 = c;
                if (sb.size() == 0) check("b2b_sb_empty", 64'd0, 64'd1);
                else check($sformatf("b2b_var_%0d", nv), variance_o, sb.pop_front());
            end
            if (c == 6) begin
                load(0, 0, 0, 28, 0, 0, 0, 200);
                sb.push_back(model(16'd4));
            end
            if (c == 10) start_i = 1'b0;
        end
        check("b2b_nvalid", 64'(nv), 64'd2);
        check("b2b_first_valid", 64'(v1), 64'd8);
        check("b2b_period", 64'(v2 - v1), 64'd9);
        check("b2b_reads", 64'(read_count), 64'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/variance_cache_reader.md
Name: variance_cache_reader

Overview:
- Read-side consumer of the 4-entry variance cache; the cache holds the window corner values of the integral image and the squared-integral image.
- On start, issues four sequential corner reads, forms the window sum and square-sum, then computes the unnormalised variance AREA*sqsum - sum^2.
- Result goes to the stage-threshold logic of the cascade classifier through a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 2, cache address width; exactly 4 corners are read.
- WORD_SIZE, 32, integral-image word width; matches pkg_integralImageCache::integralImageDepth.
- WORD_SIZE_SQ, 64, squared-integral word width; matches pkg_SQImageCache::SQImageDepth.
- AREA_W, 16, width of the window pixel count.
- VAR_W, 64, width of the variance output.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  request one variance computation; honoured only while ready_o=1.
- win_area_i  in  AREA_W  window pixel count; latched on the accepted start.
- ready_o  out  1  block idle, can accept start.
- rd_en_o  out  1  cache read strobe.
- rd_addr_o  out  ADDR_WIDTH  corner address.
- rd_data_i  in  WORD_SIZE  integral corner value; valid 1 cycle after rd_en_o.
- rd_data_sq_i  in  WORD_SIZE_SQ  squared-integral corner value; valid 1 cycle after rd_en_o.
- variance_o  out  VAR_W  AREA*sqsum - sum^2, clamped at 0.
- valid_o  out  1  variance_o valid.
- ready_i  in  1  downstream accepts the result.

Behaviour:
- Reset (synchronous, active-high; overrides everything, including mid-operation):
  - state=IDLE, ready_o=1.
  - rd_en_o=0, rd_addr_o=0, valid_o=0, variance_o=0.
  - accumulators cleared.
- Corner map and signs: addr0 = top-left A (+), addr1 = top-right B (-), addr2 = bottom-left C (-), addr3 = bottom-right D (+).
  - sum = A - B - C + D, computed modulo 2^WORD_SIZE.
  - sqsum = same combination of the squared corners, modulo 2^WORD_SIZE_SQ.
  - Wrapped integral values therefore give correct window sums.
- FSM: IDLE -> READ -> DRAIN -> MUL -> SUB -> OUT -> IDLE.
  - IDLE: ready_o=1. start_i=1 at an edge latches win_area_i, clears the accumulators, enters READ.
  - READ (4 cycles): rd_en_o=1, rd_addr_o=0,1,2,3. Read data returned in cycles 2-4 is added or subtracted per the sign map.
  - DRAIN (1 cycle): rd_en_o=0, accumulates the addr3 data.
  - MUL: registers area*sqsum (unsigned, AREA_W+WORD_SIZE_SQ bits) and sum*sum (unsigned, 2*WORD_SIZE bits).
  - SUB: signed difference at max width + 1. A negative result gives 0; a result above 2^VAR_W-1 saturates to all-ones. The result is registered into variance_o.
  - OUT: valid_o=1, variance_o held stable. Leaves for IDLE on the edge where ready_i=1; valid_o falls at that edge.
- Latency:
  - First rd_en_o is in the cycle after the start edge.
  - valid_o rises 8 cycles after the start edge.
  - Minimum start-to-start period is 9 cycles with ready_i tied high.
- start_i outside IDLE is ignored, with no queueing. Starts are not accepted in the same cycle as the OUT handshake.
- win_area_i changes after acceptance have no effect.
- ready_i is ignored outside OUT.

Decomposition:
- Package pkg_varianceCache holds:
  - ADDR_WIDTH, WORD_SIZE, WORD_SIZE_SQ, AREA_W, VAR_W.
  - enum state typedef.
  - corner-index constants CORNER_TL, CORNER_TR, CORNER_BL, CORNER_BR.
  - sign table.
- One sub-module: variance_mul_sub, holding the MUL and SUB pipeline registers with clamp/saturate logic. FSM, address sequencing and accumulation stay in the top level.

Test Plan:
- Basic: area=4, A/B/C/D = 5/7/9/21 (sum 10), sq = 1/2/3/34 (sqsum 30) -> rd_addr_o sequence 0,1,2,3 in cycles 1-4; valid_o in cycle 8; variance_o=20.
- Wrap: area=4, A=0, B=0xFFFFFFF8, C=2, D=4 (sum 10), sqsum 30 -> variance_o=20.
- Flat window: area=4, sum 28, sqsum 196 -> variance_o=0. Negative case: sum 10, sqsum 20 (80-100) -> variance_o=0 (clamped).
- Backpressure: ready_i low for 5 cycles after valid_o rises -> variance_o and valid_o held constant; start_i pulses during this period ignored, no rd_en_o; ready_o=1 one cycle after the handshake.
- Reset in READ at addr2 -> next cycle rd_en_o=0, ready_o=1, valid_o=0. A following start produces the correct fresh result, with no residue from the aborted accumulation.
- Back-to-back starts with ready_i=1 -> exactly 4 reads per result; second valid_o comes 9 cycles after the first.
